simon32_64_sched: RTL and testbench
===================================

// Module: simon32_64_sched
// PURPOSE
//  Shares one iterative Simon32/64 round engine between NUM_REQ requesters, one block at a time.
//  Round-robin arbitrates valid/ready requests (plaintext, key, tag), runs key expansion and
//  32 rounds on the engine, then returns ciphertext, tag and source index on a valid/ready port.
//  Sits between the crypto request fabric and the round datapath, replacing a fully unrolled core.
// PARAMETERS
//  NUM_REQ        2   number of requesters (1..8)
//  TAG_W          4   opaque tag width, returned unchanged with the result
//  ROUNDS_PER_CYC 1   rounds applied per RUN cycle; must be 1, 2, 4 or 8 (divides 32)
// PORTS
//  clk        in   1              clock, rising edge
//  reset      in   1              asynchronous, active-low reset
//  req_valid  in   NUM_REQ        per-requester request valid
//  req_ready  out  NUM_REQ        per-requester accept; at most one bit high
//  req_pt     in   32*NUM_REQ     plaintext, requester i in [32*i+:32]; {x,y}, x = bits 31:16
//  req_key    in   64*NUM_REQ     key, requester i in [64*i+:64]; {k3,k2,k1,k0}
//  req_tag    in   TAG_W*NUM_REQ  tag, requester i in [TAG_W*i+:TAG_W]
//  ct_valid   out  1              result valid
//  ct_ready   in   1              downstream accept
//  ct_data    out  32             ciphertext {x,y}
//  ct_tag     out  TAG_W          tag of the completed request
//  ct_src     out  $clog2(NUM_REQ) (min 1)  index of the requester served
// BEHAVIOUR
//  - Reset (reset=0): state IDLE, rr pointer 0, round counter 0, ct_valid=0, ct_data=0, ct_tag=0,
//    ct_src=0, req_ready=0. An in-flight block is dropped without a result.
//  - FSM: IDLE -> RUN on accept; RUN -> DONE after 32/ROUNDS_PER_CYC cycles; DONE -> IDLE when
//    ct_valid&&ct_ready.
//  - IDLE: grant = first asserted req_valid at or after the rr pointer, wrapping modulo NUM_REQ.
//    req_ready[grant]=1 combinationally, driven only in IDLE. Accept = valid&&ready. On accept,
//    latch pt, key, tag and src. The rr pointer becomes (grant+1) mod NUM_REQ.
//  - Requesters hold valid and payload stable until ready. Payload changes while not ready are ignored.
//  - RUN: each cycle applies ROUNDS_PER_CYC rounds: x' = y ^ f(x) ^ k_i,
//    f(x) = (x<<<1 & x<<<8) ^ x<<<2, y' = x.
//  - Round keys are generated on the fly from a 4-word key window:
//    k_{i+4} = ~k_i ^ t ^ (t>>>1) ^ z0[i] ^ 3, where t = (k_{i+3}>>>3) ^ k_{i+1}.
//    z0 is the 62-bit Simon sequence. Indexing is mod 62 (only 0..27 used). All arithmetic is 16-bit.
//  - Latency: an accept at edge T sets ct_valid from edge T+32/ROUNDS_PER_CYC (32 cycles for R=1).
//  - DONE: ct_valid=1; ct_data/tag/src are stable while ct_valid=1 and ct_ready=0, with unbounded
//    backpressure. No accept occurs in DONE or RUN.
//  - After the result handshake, IDLE lasts at least 1 cycle. Minimum spacing is 32/R+2 cycles per block.
//  - ct_valid drops the cycle after the handshake. ct_data is held (not cleared) until the next completion.
//  - NUM_REQ=1: the arbiter degenerates to a pass-through and ct_src is constant 0.
// CONFIGURATION
//  - SIMON_SCHED_PERF_EN defined: adds output ports perf_done[31:0] (count of completed result
//    handshakes) and perf_stall[31:0] (cycles in DONE with ct_ready=0).
//  - Both counters reset to 0 and wrap at 2^32.
//  - Macro undefined: the ports and counters are absent. All other behaviour is identical.
// STRUCTURE
//  - Package simon32_64_pkg: WORD_W=16, ROUNDS=32, Z0 (62-bit constant), C_CONST=16'hFFFC,
//    state enum {IDLE,RUN,DONE}, and functions rol16/ror16.
//  - Sub-module simon32_64_round: one combinational round plus one key-window step.
//    It is instanced ROUNDS_PER_CYC times in a chain.
//  - The arbiter, FSM, counter and output registers stay in the top module.
// TESTING
//  - Known answer: key 64'h1918111009080100, pt 32'h65656877 on req 0 -> ct_data 32'hc69be9bb,
//    ct_src 0, ct_valid at accept+32.
//  - Round robin: NUM_REQ=2, both valid continuously with tags 3 and 5 -> results alternate
//    src 0,1,0,1 and tags match sources.
//  - Backpressure: hold ct_ready=0 for 10 cycles in DONE -> ct_* stable, req_ready=0 throughout;
//    release -> ct_valid low the next cycle.
//  - Reset mid-RUN: assert reset at round 15 -> ct_valid=0 and req_ready=0 immediately.
//    Rerunning the known-answer vector gives the correct result.
//  - ROUNDS_PER_CYC=4: known-answer vector -> same ciphertext with ct_valid at accept+8.
//    Spacing is 10 cycles per block.
//  - Perf (macro defined): 3 blocks with 4 stall cycles total -> perf_done=3, perf_stall=4.

Source files
------------

// File: rtl/simon32_64_pkg.sv
// Shared constants, state encoding and rotate helpers for the shared Simon32/64 engine.
package simon32_64_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned ROUNDS = 32;

  // MSB holds z0[0], so the sequence reads left to right as published.
  localparam logic [61:0] Z0 =
    62'b1111101000100101011000011100110_1111101000100101011000011100110;

  localparam logic [WORD_W-1:0] C_CONST = 16'hFFFC;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  function automatic logic [WORD_W-1:0] rol16(input logic [WORD_W-1:0] v, input int unsigned n);
    return (v << n) | (v >> (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] ror16(input logic [WORD_W-1:0] v, input int unsigned n);
    return (v >> n) | (v << (WORD_W - n));
  endfunction

  function automatic logic z0_bit(input logic [4:0] i);
    return Z0[6'd61 - {1'b0, i}];
  endfunction

endpackage

// File: rtl/simon32_64_round.sv
// One combinational Simon32/64 round plus one step of the 4-word key window.
module simon32_64_round
  import simon32_64_pkg::*;
(
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [63:0] kwin,
  input  logic [4:0]  idx,
  output logic [15:0] x_next,
  output logic [15:0] y_next,
  output logic [63:0] kwin_next
);

  logic [15:0] t;
  logic [15:0] k_new;

  // kwin = {k_{i+3}, k_{i+2}, k_{i+1}, k_i}; round i consumes k_i and produces k_{i+4}.
  always_comb begin
    t         = ror16(kwin[63:48], 3) ^ kwin[31:16];
    k_new     = kwin[15:0] ^ C_CONST ^ t ^ ror16(t, 1) ^ {15'd0, z0_bit(idx)};
    x_next    = y ^ (rol16(x, 1) & rol16(x, 8)) ^ rol16(x, 2) ^ kwin[15:0];
    y_next    = x;
    kwin_next = {k_new, kwin[63:16]};
  end

endmodule

// File: rtl/simon32_64_sched.sv
// Round-robin scheduler sharing one iterative Simon32/64 engine between NUM_REQ requesters.
// Optional SIMON_SCHED_PERF_EN adds perf_done / perf_stall counters.
module simon32_64_sched
  import simon32_64_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TAG_W          = 4,
  parameter int unsigned ROUNDS_PER_CYC = 1,
  localparam int unsigned SRC_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [32*NUM_REQ-1:0]    req_pt,
  input  logic [64*NUM_REQ-1:0]    req_key,
  input  logic [TAG_W*NUM_REQ-1:0] req_tag,
  output logic                     ct_valid,
  input  logic                     ct_ready,
  output logic [31:0]              ct_data,
  output logic [TAG_W-1:0]         ct_tag,
  output logic [SRC_W-1:0]         ct_src
`ifdef SIMON_SCHED_PERF_EN
  ,
  output logic [31:0]              perf_done,
  output logic [31:0]              perf_stall
`endif
);

  localparam logic [4:0] LAST_RND = 5'(ROUNDS - ROUNDS_PER_CYC);

  state_e           state_q;
  logic [15:0]      x_q, y_q;
  logic [63:0]      k_q;
  logic [4:0]       rnd_q;
  logic [SRC_W-1:0] rr_q;

  logic             found, any_hi, accept;
  logic [SRC_W-1:0] g_hi, g_lo, grant, rr_next;
  logic [31:0]      pt_sel;
  logic [63:0]      key_sel;
  logic [TAG_W-1:0] tag_sel;

  // Grant the lowest valid index at or above rr_q, otherwise wrap to the lowest valid index.
  always_comb begin
    found  = 1'b0;
    any_hi = 1'b0;
    g_hi   = '0;
    g_lo   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        found = 1'b1;
        g_lo  = SRC_W'(i);
        if (SRC_W'(i) >= rr_q) begin
          any_hi = 1'b1;
          g_hi   = SRC_W'(i);
        end
      end
    end
    grant     = any_hi ? g_hi : g_lo;
    pt_sel    = '0;
    key_sel   = '0;
    tag_sel   = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == SRC_W'(i)) begin
        pt_sel       = req_pt[32*i +: 32];
        key_sel      = req_key[64*i +: 64];
        tag_sel      = req_tag[TAG_W*i +: TAG_W];
        req_ready[i] = reset && (state_q == IDLE) && found;
      end
    end
    rr_next = (grant == SRC_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
    accept  = |(req_valid & req_ready);
  end

  logic [15:0] x_c [ROUNDS_PER_CYC+1];
  logic [15:0] y_c [ROUNDS_PER_CYC+1];
  logic [63:0] k_c [ROUNDS_PER_CYC+1];

  assign x_c[0] = x_q;
  assign y_c[0] = y_q;
  assign k_c[0] = k_q;

  for (genvar j = 0; j < ROUNDS_PER_CYC; j++) begin : g_chain
    simon32_64_round u_round (
      .x         (x_c[j]),
      .y         (y_c[j]),
      .kwin      (k_c[j]),
      .idx       (rnd_q + 5'(j)),
      .x_next    (x_c[j+1]),
      .y_next    (y_c[j+1]),
      .kwin_next (k_c[j+1])
    );
  end

  // ct_tag/ct_src are captured at accept; they only matter while ct_valid is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      rnd_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      k_q      <= '0;
      ct_valid <= 1'b0;
      ct_data  <= '0;
      ct_tag   <= '0;
      ct_src   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            x_q     <= pt_sel[31:16];
            y_q     <= pt_sel[15:0];
            k_q     <= key_sel;
            ct_tag  <= tag_sel;
            ct_src  <= grant;
            rr_q    <= rr_next;
            rnd_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          x_q   <= x_c[ROUNDS_PER_CYC];
          y_q   <= y_c[ROUNDS_PER_CYC];
          k_q   <= k_c[ROUNDS_PER_CYC];
          rnd_q <= rnd_q + 5'(ROUNDS_PER_CYC);
          if (rnd_q == LAST_RND) begin
            ct_data  <= {x_c[ROUNDS_PER_CYC], y_c[ROUNDS_PER_CYC]};
            ct_valid <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (ct_ready) begin
            ct_valid <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SIMON_SCHED_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_done  <= '0;
      perf_stall <= '0;
    end else if (state_q == DONE) begin
      if (ct_ready) perf_done  <= perf_done + 32'd1;
      else          perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_simon32_64_sched.sv
// Randomized self-checking bench for simon32_64_sched against a behavioural Simon/arbiter model.
module tb_simon32_64_sched;

  localparam int unsigned N   = 2;
  localparam int unsigned TW  = 4;
  localparam int unsigned R   = 1;
  localparam int unsigned SW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned LAT = 32 / R;
  localparam logic [31:0] KAT_PT  = 32'h65656877;
  localparam logic [63:0] KAT_KEY = 64'h1918111009080100;
  localparam logic [31:0] KAT_CT  = 32'hc69be9bb;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ct_ready = 1'b1;
  wire  [N-1:0]    req_valid;
  wire  [N-1:0]    req_ready;
  wire  [32*N-1:0] req_pt;
  wire  [64*N-1:0] req_key;
  wire  [TW*N-1:0] req_tag;
  wire             ct_valid;
  wire  [31:0]     ct_data;
  wire  [TW-1:0]   ct_tag;
  wire  [SW-1:0]   ct_src;
`ifdef SIMON_SCHED_PERF_EN
  wire  [31:0]     perf_done;
  wire  [31:0]     perf_stall;
`endif

  logic          vld_a [N];
  logic [31:0]   pt_a  [N];
  logic [63:0]   key_a [N];
  logic [TW-1:0] tag_a [N];
  logic          acc_a [N];

  for (genvar g = 0; g < N; g++) begin : g_drv
    assign req_valid[g]           = vld_a[g];
    assign req_pt[32*g +: 32]     = pt_a[g];
    assign req_key[64*g +: 64]    = key_a[g];
    assign req_tag[TW*g +: TW]    = tag_a[g];
  end

  always #5 clk = ~clk;

  simon32_64_sched #(
    .NUM_REQ        (N),
    .TAG_W          (TW),
    .ROUNDS_PER_CYC (R)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_pt    (req_pt),
    .req_key   (req_key),
    .req_tag   (req_tag),
    .ct_valid  (ct_valid),
    .ct_ready  (ct_ready),
    .ct_data   (ct_data),
    .ct_tag    (ct_tag),
    .ct_src    (ct_src)
`ifdef SIMON_SCHED_PERF_EN
    ,
    .perf_done  (perf_done),
    .perf_stall (perf_stall)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  logic [0:61] zseq = 62'b11111010001001010110000111001101111101000100101011000011100110;

  function automatic logic [15:0] rl(input logic [15:0] v, input int n);
    logic [31:0] d;
    d = {v, v} << n;
    return d[31:16];
  endfunction

  function automatic logic [15:0] rr(input logic [15:0] v, input int n);
    logic [31:0] d;
    d = {v, v} >> n;
    return d[15:0];
  endfunction

  function automatic logic [31:0] enc(input logic [31:0] pt, input logic [63:0] key);
    logic [15:0] k [32];
    logic [15:0] x, y, t, tmp;
    for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
    for (int i = 4; i < 32; i++) begin
      t    = rr(k[i-1], 3) ^ k[i-3];
      t    = t ^ rr(t, 1);
      k[i] = ~k[i-4] ^ t ^ {15'd0, zseq[i-4]} ^ 16'd3;
    end
    x = pt[31:16];
    y = pt[15:0];
    for (int i = 0; i < 32; i++) begin
      tmp = x;
      x   = y ^ (rl(x, 1) & rl(x, 8)) ^ rl(x, 2) ^ k[i];
      y   = tmp;
    end
    return {x, y};
  endfunction

  function automatic int pick(input int rrp);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (rrp + k) % N;
      if (vld_a[c]) return c;
    end
    return -1;
  endfunction

  int            m_st = 0;  // 0 idle, 1 busy, 2 result pending
  int            m_cnt = 0;
  int            m_rr = 0;
  int            g_m, g_c;
  logic [31:0]   m_data = '0, m_pend = '0;
  logic [TW-1:0] m_tag = '0, m_ptag = '0;
  int            m_src = 0, m_psrc = 0;
  logic [31:0]   m_pd = '0, m_ps = '0;
  logic [N-1:0]  exp_rdy;
  int            hs_src[$];
  int            hs_tag[$];

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_st = 0; m_rr = 0; m_cnt = 0; m_data = '0; m_pd = '0; m_ps = '0;
    end else begin
      case (m_st)
        0: begin
          g_m = pick(m_rr);
          if (g_m >= 0) begin
            m_pend = enc(pt_a[g_m], key_a[g_m]);
            m_ptag = tag_a[g_m];
            m_psrc = g_m;
            m_rr   = (g_m + 1) % N;
            m_cnt  = LAT;
            m_st   = 1;
          end
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_st = 2; m_data = m_pend; m_tag = m_ptag; m_src = m_psrc;
          end
        end
        default: begin
          if (ct_ready) begin m_st = 0; m_pd++; end
          else m_ps++;
        end
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    g_c     = (reset && m_st == 0) ? pick(m_rr) : -1;
    exp_rdy = (g_c >= 0) ? (N'(1) << g_c) : '0;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("ct_valid", 64'(ct_valid), 64'(m_st == 2));
    chk("ct_data", 64'(ct_data), 64'(m_data));
    if (m_st == 2) begin
      chk("ct_tag", 64'(ct_tag), 64'(m_tag));
      chk("ct_src", 64'(ct_src), 64'(m_src));
    end
`ifdef SIMON_SCHED_PERF_EN
    chk("perf_done", 64'(perf_done), 64'(m_pd));
    chk("perf_stall", 64'(perf_stall), 64'(m_ps));
`endif
    for (int c = 0; c < N; c++) acc_a[c] = vld_a[c] && (((req_ready >> c) & N'(1)) != '0);
    if (ct_valid && ct_ready) begin
      hs_src.push_back(int'(ct_src));
      hs_tag.push_back(int'(ct_tag));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic any_vld();
    for (int i = 0; i < N; i++) if (vld_a[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drop_acc();
    for (int i = 0; i < N; i++) if (acc_a[i]) vld_a[i] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    ct_ready = 1'b1;
    while (n < 500 && (any_vld() || m_st != 0)) begin
      tick();
      drop_acc();
      n++;
    end
    chk("drain_bound", 64'(n < 500), 64'd1);
  endtask

  task automatic run_kat();
    int n = 0;
    pt_a[0] = KAT_PT; key_a[0] = KAT_KEY; tag_a[0] = TW'(4'hA); vld_a[0] = 1'b1;
    do begin tick(); n++; end while (!acc_a[0] && n < 50);
    chk("kat_accept", 64'(acc_a[0]), 64'd1);
    vld_a[0] = 1'b0;
    n = 0;
    while (!ct_valid && n < 200) begin tick(); n++; end
    chk("kat_latency", 64'(n), 64'(LAT));
    chk("kat_data", 64'(ct_data), 64'(KAT_CT));
    chk("kat_src", 64'(ct_src), 64'd0);
  endtask

  initial begin
    logic [31:0]   d;
    logic [TW-1:0] t;
    logic [SW-1:0] s;
    int            n;
    for (int i = 0; i < N; i++) begin
      vld_a[i] = 1'b0; pt_a[i] = '0; key_a[i] = '0; tag_a[i] = '0; acc_a[i] = 1'b0;
    end
    vld_a[0] = 1'b1;
    tick(); tick();
    chk("rst_valid", 64'(ct_valid), 64'd0);
    chk("rst_data", 64'(ct_data), 64'd0);
    chk("rst_tag", 64'(ct_tag), 64'd0);
    chk("rst_src", 64'(ct_src), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    vld_a[0] = 1'b0;
    reset = 1'b1;
    chk("model_kat", 64'(enc(KAT_PT, KAT_KEY)), 64'(KAT_CT));
    tick();
    run_kat();

    // Round robin: both requesters continuously valid, pointer starts at 1 after the KAT.
    drain();
    hs_src.delete();
    hs_tag.delete();
    for (int i = 0; i < N; i++) begin
      pt_a[i] = $urandom; key_a[i] = {$urandom, $urandom}; vld_a[i] = 1'b1;
    end
    tag_a[0] = TW'(3);
    tag_a[1] = TW'(5);
    n = 0;
    while (hs_src.size() < 4 && n < 400) begin tick(); n++; end
    chk("rr_count", 64'(hs_src.size()), 64'd4);
    for (int k = 0; k < hs_src.size(); k++) begin
      chk("rr_src", 64'(hs_src[k]), 64'((k + 1) % 2));
      chk("rr_tag", 64'(hs_tag[k]), ((k + 1) % 2 == 0) ? 64'd3 : 64'd5);
    end
    drain();

    // Backpressure: result held for 10 cycles with another request pending.
    ct_ready = 1'b0;
    pt_a[0] = $urandom; key_a[0] = {$urandom, $urandom}; tag_a[0] = TW'($urandom);
    vld_a[0] = 1'b1;
    n = 0;
    while (!ct_valid && n < 200) begin tick(); drop_acc(); n++; end
    chk("bp_valid", 64'(ct_valid), 64'd1);
    d = ct_data; t = ct_tag; s = ct_src;
    pt_a[1] = $urandom; key_a[1] = {$urandom, $urandom}; vld_a[1] = 1'b1;
    repeat (10) begin
      tick();
      chk("bp_hold_valid", 64'(ct_valid), 64'd1);
      chk("bp_hold_data", 64'(ct_data), 64'(d));
      chk("bp_hold_tag", 64'(ct_tag), 64'(t));
      chk("bp_hold_src", 64'(ct_src), 64'(s));
      chk("bp_ready", 64'(req_ready), 64'd0);
    end
    ct_ready = 1'b1;
    tick();
    chk("bp_release", 64'(ct_valid), 64'd0);

    // Random traffic with random backpressure.
    repeat (2500) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (!vld_a[i] || acc_a[i]) begin
          vld_a[i] = ($urandom_range(0, 2) != 0);
          pt_a[i]  = $urandom;
          key_a[i] = {$urandom, $urandom};
          tag_a[i] = TW'($urandom);
        end
      end
      ct_ready = ($urandom_range(0, 9) < 7);
    end

    // Reset in the middle of a block.
    drain();
    pt_a[0] = KAT_PT; key_a[0] = KAT_KEY; vld_a[0] = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!acc_a[0] && n < 50);
    vld_a[0] = 1'b0;
    vld_a[1] = 1'b1;
    repeat (15) tick();
    #1 reset = 1'b0;
    #1;
    chk("midrst_valid", 64'(ct_valid), 64'd0);
    chk("midrst_ready", 64'(req_ready), 64'd0);
    tick(); tick();
    vld_a[1] = 1'b0;
    reset = 1'b1;
    tick();
    run_kat();
    drain();

`ifdef SIMON_SCHED_PERF_EN
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int b = 0; b < 3; b++) begin
      ct_ready = 1'b0;
      pt_a[0] = $urandom; key_a[0] = {$urandom, $urandom}; vld_a[0] = 1'b1;
      n = 0;
      while (!ct_valid && n < 200) begin tick(); drop_acc(); n++; end
      repeat ((b == 2) ? 2 : 1) tick();
      ct_ready = 1'b1;
      tick();
    end
    chk("perf_done_lit", 64'(perf_done), 64'd3);
    chk("perf_stall_lit", 64'(perf_stall), 64'd4);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
